tlb_maint_ctrl: RTL and testbench
=================================

TLB_MAINT_CTRL -- requirements
Module: tlb_maint_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 32, meaning number of TLB entries (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have ports req_valid/req_ready  input/output  1/1  request handshake from commit stage.
REQ-005 SHALL have port req_op  input  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, 5..7 illegal.
REQ-006 SHALL have ports req_index  input  5 (TLBIDX.index); req_entry  input  89 (CSR entry bundle); req_inv_op  input  5; req_inv_asid  input  10; req_inv_vpn  input  19.
REQ-007 SHALL use entry bundle layout: [88:70] vppn, [69:60] asid, [59] g, [58:53] ps, [52] e, [51] v0, [50] d0, [49:48] mat0, [47:46] plv0, [45:26] ppn0, [25] v1, [24] d1, [23:22] mat1, [21:20] plv1, [19:0] ppn1.
REQ-008 SHALL have ports s1_fetch  output  1; s1_vppn  output  19; s1_asid  output  10; s1_found  input  1; s1_index  input  5 (TLB search port 1, registered result one cycle after fetch).
REQ-009 SHALL have ports we  output  1; w_index  output  5; w_entry  output  89 (TLB write port).
REQ-010 SHALL have ports r_index  output  5; r_entry  input  89 (TLB combinational read port).
REQ-011 SHALL have ports inv_en  output  1; inv_op  output  5; inv_asid  output  10; inv_vpn  output  19.
REQ-012 SHALL have ports resp_valid/resp_ready  output/input  1/1; resp_found  output  1; resp_index  output  5; resp_entry  output  89; resp_err  output  1.
REQ-013 SHALL have port tlb_changed  output  1  one-cycle pulse telling fetch/LSU to discard in-flight translations.

Function
REQ-014 SHALL implement FSM states IDLE, SRCH_REQ, SRCH_RSP, RD, WR, INV, DONE.
REQ-015 SHALL assert req_ready iff state==IDLE; a request is accepted on req_valid&&req_ready and all payload fields are latched that cycle.
REQ-016 SHALL transition on accept: SRCH->SRCH_REQ, RD->RD, WR/FILL->WR, INV->INV, illegal op->DONE with resp_err=1.
REQ-017 SRCH_REQ SHALL drive s1_fetch=1 with latched vppn/asid for exactly one cycle, then go to SRCH_RSP.
REQ-018 SRCH_RSP SHALL capture resp_found=s1_found and resp_index=s1_index (index 0 when not found), then go to DONE.
REQ-019 RD SHALL drive r_index=latched index and capture resp_entry=r_entry when r_entry[52]=1, else all-zero; index>=TLBNUM SHALL yield all-zero entry; then DONE.
REQ-020 WR SHALL pulse we for exactly one cycle with w_entry=latched entry and w_index=latched index (WR) or latched fill index (FILL); then DONE.
REQ-021 SHALL keep a free-running fill counter, reset 0, incrementing every cycle and wrapping TLBNUM-1->0; FILL samples it at accept.
REQ-022 INV with inv_op 0..6 SHALL pulse inv_en one cycle with latched op/asid/vpn; inv_op>6 SHALL not pulse inv_en and SHALL set resp_err=1; then DONE.
REQ-023 SHALL pulse tlb_changed exactly one cycle after any we or inv_en pulse.
REQ-024 DONE SHALL hold resp_valid=1 and all resp fields stable until resp_ready; on resp_valid&&resp_ready go to IDLE; resp_ready=1 before DONE SHALL be ignored.
REQ-025 we, inv_en, s1_fetch SHALL be 0 in every state other than their own; resp fields not set by the current op SHALL be 0.
REQ-026 Latency accept->resp_valid SHALL be: SRCH 3, RD 2, WR/FILL 2, INV 2, illegal 1 cycle(s).

Reset
REQ-027 On rst, SHALL enter IDLE, clear fill counter and all outputs to 0; resp_err, resp_found, resp_entry 0.
REQ-028 rst mid-operation SHALL abort it with no response, no we/inv_en pulse in the reset cycle, and no tlb_changed afterwards.

Verification
REQ-029 SRCH vppn=0x12345 asid=3 with s1_found=1,s1_index=7 -> s1_fetch one cycle, resp_valid 3 cycles after accept, resp_found=1, resp_index=7.
REQ-030 FILL accepted when fill counter=31 (TLBNUM=32) -> we pulse with w_index=31, tlb_changed next cycle; next FILL after counter wrap uses small index, counter observed 0 after 31.
REQ-031 RD index=5 with r_entry[52]=0 -> resp_entry=0; RD index=5 with r_entry[52]=1 -> resp_entry==r_entry.
REQ-032 INV inv_op=5 asid=0x2A vpn=0x00100 -> inv_en one cycle with those values; inv_op=9 -> no inv_en, resp_err=1, latency 2.
REQ-033 req_op=6 -> resp_err=1 after 1 cycle; resp_ready held 0 for 4 cycles -> resp_valid and fields stable, req_ready 0 throughout.
REQ-034 rst asserted in WR state -> we=0, state IDLE, req_ready=1 next cycle, no resp_valid, no tlb_changed.

Source files
------------

// File: rtl/tlb_maint_ctrl.sv
// rtl/tlb_maint_ctrl.sv - TLB maintenance sequencer for SRCH/RD/WR/FILL/INV commit-stage ops
// Runs one maintenance op at a time on the TLB search, read, write and invalidate ports.
module tlb_maint_ctrl #(
   parameter int TLBNUM = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [4:0]  req_index,
   input  logic [88:0] req_entry,
   input  logic [4:0]  req_inv_op,
   input  logic [9:0]  req_inv_asid,
   input  logic [18:0] req_inv_vpn,
   output logic        s1_fetch,
   output logic [18:0] s1_vppn,
   output logic [9:0]  s1_asid,
   input  logic        s1_found,
   input  logic [4:0]  s1_index,
   output logic        we,
   output logic [4:0]  w_index,
   output logic [88:0] w_entry,
   output logic [4:0]  r_index,
   input  logic [88:0] r_entry,
   output logic        inv_en,
   output logic [4:0]  inv_op,
   output logic [9:0]  inv_asid,
   output logic [18:0] inv_vpn,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_found,
   output logic [4:0]  resp_index,
   output logic [88:0] resp_entry,
   output logic        resp_err,
   output logic        tlb_changed
);
   typedef enum logic [2:0] {IDLE, SRCH_REQ, SRCH_RSP, RD, WR, INV, DONE} state_t;

   localparam logic [2:0] OP_SRCH    = 3'd0;
   localparam logic [2:0] OP_RD      = 3'd1;
   localparam logic [2:0] OP_WR      = 3'd2;
   localparam logic [2:0] OP_FILL    = 3'd3;
   localparam logic [2:0] OP_INV     = 3'd4;
   localparam logic [4:0] FILL_MAX   = 5'(TLBNUM - 1);
   localparam logic [4:0] INV_OP_MAX = 5'd6;

   state_t      state_q, state_d;
   logic [4:0]  fill_cnt_q, fill_cnt_d;
   logic [4:0]  idx_q, idx_d;
   logic [88:0] entry_q, entry_d;
   logic [4:0]  iop_q, iop_d;
   logic [9:0]  iasid_q, iasid_d;
   logic [18:0] ivpn_q, ivpn_d;
   logic        resp_found_q, resp_found_d;
   logic [4:0]  resp_index_q, resp_index_d;
   logic [88:0] resp_entry_q, resp_entry_d;
   logic        resp_err_q, resp_err_d;
   logic        tlb_changed_q, tlb_changed_d;
   logic        rd_in_range;

   assign rd_in_range = int'(idx_q) < TLBNUM;

   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = (fill_cnt_q == FILL_MAX) ? 5'd0 : fill_cnt_q + 5'd1;
      idx_d        = idx_q;
      entry_d      = entry_q;
      iop_d        = iop_q;
      iasid_d      = iasid_q;
      ivpn_d       = ivpn_q;
      resp_found_d = resp_found_q;
      resp_index_d = resp_index_q;
      resp_entry_d = resp_entry_q;
      resp_err_d   = resp_err_q;
      req_ready    = 1'b0;
      s1_fetch     = 1'b0;
      s1_vppn      = 19'd0;
      s1_asid      = 10'd0;
      we           = 1'b0;
      w_index      = 5'd0;
      w_entry      = 89'd0;
      r_index      = 5'd0;
      inv_en       = 1'b0;
      inv_op       = 5'd0;
      inv_asid     = 10'd0;
      inv_vpn      = 19'd0;
      resp_valid   = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               // FILL takes its slot from the free-running counter at accept time
               idx_d        = (req_op == OP_FILL) ? fill_cnt_q : req_index;
               entry_d      = req_entry;
               iop_d        = req_inv_op;
               iasid_d      = req_inv_asid;
               ivpn_d       = req_inv_vpn;
               resp_found_d = 1'b0;
               resp_index_d = 5'd0;
               resp_entry_d = 89'd0;
               resp_err_d   = 1'b0;
               case (req_op)
                  OP_SRCH:         state_d = SRCH_REQ;
                  OP_RD:           state_d = RD;
                  OP_WR, OP_FILL:  state_d = WR;
                  OP_INV:          state_d = INV;
                  default: begin
                     state_d    = DONE;
                     resp_err_d = 1'b1;
                  end
               endcase
            end
         end
         SRCH_REQ: begin
            s1_fetch = 1'b1;
            s1_vppn  = entry_q[88:70];
            s1_asid  = entry_q[69:60];
            state_d  = SRCH_RSP;
         end
         SRCH_RSP: begin
            resp_found_d = s1_found;
            resp_index_d = s1_found ? s1_index : 5'd0;
            state_d      = DONE;
         end
         RD: begin
            r_index = idx_q;
            if (rd_in_range && r_entry[52]) begin
               resp_entry_d = r_entry;
            end
            state_d = DONE;
         end
         WR: begin
            we      = 1'b1;
            w_index = idx_q;
            w_entry = entry_q;
            state_d = DONE;
         end
         INV: begin
            if (iop_q <= INV_OP_MAX) begin
               inv_en   = 1'b1;
               inv_op   = iop_q;
               inv_asid = iasid_q;
               inv_vpn  = ivpn_q;
            end else begin
               resp_err_d = 1'b1;
            end
            state_d = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // An op interrupted by reset must not touch the TLB in the reset cycle
      if (rst) begin
         s1_fetch = 1'b0;
         we       = 1'b0;
         inv_en   = 1'b0;
      end
      tlb_changed_d = we || inv_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         fill_cnt_q    <= 5'd0;
         idx_q         <= 5'd0;
         entry_q       <= 89'd0;
         iop_q         <= 5'd0;
         iasid_q       <= 10'd0;
         ivpn_q        <= 19'd0;
         resp_found_q  <= 1'b0;
         resp_index_q  <= 5'd0;
         resp_entry_q  <= 89'd0;
         resp_err_q    <= 1'b0;
         tlb_changed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fill_cnt_q    <= fill_cnt_d;
         idx_q         <= idx_d;
         entry_q       <= entry_d;
         iop_q         <= iop_d;
         iasid_q       <= iasid_d;
         ivpn_q        <= ivpn_d;
         resp_found_q  <= resp_found_d;
         resp_index_q  <= resp_index_d;
         resp_entry_q  <= resp_entry_d;
         resp_err_q    <= resp_err_d;
         tlb_changed_q <= tlb_changed_d;
      end
   end

   assign resp_found  = resp_found_q;
   assign resp_index  = resp_index_q;
   assign resp_entry  = resp_entry_q;
   assign resp_err    = resp_err_q;
   assign tlb_changed = tlb_changed_q;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb/tb_tlb_maint_ctrl.sv - directed plus randomized bench for tlb_maint_ctrl
// The bench plays the TLB and keeps its own reference copy of the table contents.
module tb_tlb_maint_ctrl;
   localparam int TLBNUM = 32;
   localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [4:0]  req_index;
   logic [88:0] req_entry;
   logic [4:0]  req_inv_op;
   logic [9:0]  req_inv_asid;
   logic [18:0] req_inv_vpn;
   logic        s1_fetch;
   logic [18:0] s1_vppn;
   logic [9:0]  s1_asid;
   logic        s1_found = 1'b0;
   logic [4:0]  s1_index = 5'd0;
   logic        we;
   logic [4:0]  w_index;
   logic [88:0] w_entry;
   logic [4:0]  r_index;
   logic [88:0] r_entry;
   logic        inv_en;
   logic [4:0]  inv_op;
   logic [9:0]  inv_asid;
   logic [18:0] inv_vpn;
   logic        resp_valid, resp_ready;
   logic        resp_found;
   logic [4:0]  resp_index;
   logic [88:0] resp_entry;
   logic        resp_err;
   logic        tlb_changed;

   tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_index(req_index), .req_entry(req_entry), .req_inv_op(req_inv_op),
      .req_inv_asid(req_inv_asid), .req_inv_vpn(req_inv_vpn),
      .s1_fetch(s1_fetch), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index),
      .we(we), .w_index(w_index), .w_entry(w_entry),
      .r_index(r_index), .r_entry(r_entry),
      .inv_en(inv_en), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
      .resp_index(resp_index), .resp_entry(resp_entry), .resp_err(resp_err),
      .tlb_changed(tlb_changed)
   );

   int total = 0;
   int bad = 0;

   logic [88:0] tlb_mem [TLBNUM];
   logic [88:0] ref_mem [TLBNUM];

   int cyc = 0;
   int we_tot = 0, inv_tot = 0, fetch_tot = 0, chg_tot = 0;
   logic        last_pulse = 1'b0;
   logic        chk_on = 1'b0;
   logic [4:0]  w_idx_seen;
   logic [88:0] w_ent_seen;
   logic [4:0]  iop_seen;
   logic [9:0]  iasid_seen;
   logic [18:0] ivpn_seen, vppn_seen;
   logic [9:0]  asid_seen;

   int          lat;
   logic [4:0]  fill_exp;
   logic        got_found, got_err;
   logic [4:0]  got_idx;
   logic [88:0] got_ent;

   task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First valid entry whose vppn matches and whose asid matches or is global
   function automatic logic [5:0] tlb_search(input logic use_ref, input logic [18:0] vppn,
                                             input logic [9:0] asid);
      logic [88:0] e;
      for (int i = 0; i < TLBNUM; i++) begin
         e = use_ref ? ref_mem[i] : tlb_mem[i];
         if (e[52] && e[88:70] == vppn && (e[59] || e[69:60] == asid)) return {1'b1, 5'(i)};
      end
      return 6'd0;
   endfunction

   function automatic logic [88:0] mk_entry(input logic [18:0] vppn, input logic [9:0] asid,
                                            input logic g, input logic e);
      logic [88:0] x;
      x[31:0]  = $urandom;
      x[63:32] = $urandom;
      x[88:64] = 25'($urandom);
      x[88:70] = vppn;
      x[69:60] = asid;
      x[59]    = g;
      x[52]    = e;
      return x;
   endfunction

   assign r_entry = tlb_mem[r_index];

   always @(posedge clk) begin
      if (rst) begin
         cyc <= 0;
         for (int i = 0; i < TLBNUM; i++) tlb_mem[i] <= '0;
      end else begin
         cyc <= cyc + 1;
         if (we) tlb_mem[w_index] <= w_entry;
      end
      last_pulse <= !rst && (we || inv_en);
      if (we) begin
         we_tot     <= we_tot + 1;
         w_idx_seen <= w_index;
         w_ent_seen <= w_entry;
      end
      if (inv_en) begin
         inv_tot    <= inv_tot + 1;
         iop_seen   <= inv_op;
         iasid_seen <= inv_asid;
         ivpn_seen  <= inv_vpn;
      end
      if (s1_fetch) begin
         fetch_tot <= fetch_tot + 1;
         vppn_seen <= s1_vppn;
         asid_seen <= s1_asid;
         {s1_found, s1_index} <= tlb_search(1'b0, s1_vppn, s1_asid);
      end
      if (tlb_changed) chg_tot <= chg_tot + 1;
   end

   always @(negedge clk) begin
      if (chk_on && !rst) chk("tlb_changed_follows_pulse", tlb_changed, last_pulse);
   end

   task automatic send(input logic [2:0] op, input logic [4:0] idx, input logic [88:0] ent,
                       input logic [4:0] iop, input logic [9:0] ia, input logic [18:0] iv,
                       input int align, input logic early);
      @(negedge clk);
      while (align >= 0 && (cyc % TLBNUM) != align) @(negedge clk);
      chk("req_ready_idle", req_ready, 1'b1);
      fill_exp     = 5'(cyc % TLBNUM);
      req_valid    = 1'b1;
      req_op       = op;
      req_index    = idx;
      req_entry    = ent;
      req_inv_op   = iop;
      req_inv_asid = ia;
      req_inv_vpn  = iv;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_op       = 3'($urandom);
      req_index    = 5'($urandom);
      req_entry    = mk_entry(19'($urandom), 10'($urandom), 1'b0, 1'b1);
      req_inv_op   = 5'($urandom);
      resp_ready   = early;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 8);
      got_found = resp_found;
      got_idx   = resp_index;
      got_ent   = resp_entry;
      got_err   = resp_err;
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("resp_valid_drops", resp_valid, 1'b0);
      chk("req_ready_back", req_ready, 1'b1);
   endtask

   task automatic run(input logic [2:0] op, input logic [4:0] idx, input logic [88:0] ent,
                      input logic [4:0] iop, input logic [9:0] ia, input logic [18:0] iv,
                      input int align);
      int          b_we, b_inv, b_fetch, b_chg, exp_lat, exp_we, exp_inv, exp_fetch;
      logic        exp_found, exp_err;
      logic [4:0]  exp_idx, widx;
      logic [88:0] exp_ent;
      logic [5:0]  sr;
      b_we = we_tot; b_inv = inv_tot; b_fetch = fetch_tot; b_chg = chg_tot;
      send(op, idx, ent, iop, ia, iv, align, 1'($urandom));
      exp_lat = 1; exp_we = 0; exp_inv = 0; exp_fetch = 0;
      exp_found = 1'b0; exp_err = 1'b0; exp_idx = 5'd0; exp_ent = '0; widx = idx;
      case (op)
         OP_SRCH: begin
            exp_lat = 3; exp_fetch = 1;
            sr = tlb_search(1'b1, ent[88:70], ent[69:60]);
            exp_found = sr[5]; exp_idx = sr[4:0];
         end
         OP_RD: begin
            exp_lat = 2;
            if (ref_mem[idx][52]) exp_ent = ref_mem[idx];
         end
         OP_WR, OP_FILL: begin
            exp_lat = 2; exp_we = 1;
            widx = (op == OP_FILL) ? fill_exp : idx;
            ref_mem[widx] = ent;
         end
         OP_INV: begin
            exp_lat = 2;
            if (iop <= 5'd6) exp_inv = 1; else exp_err = 1'b1;
         end
         default: exp_err = 1'b1;
      endcase
      chk("latency", lat, exp_lat);
      chk("resp_found", got_found, exp_found);
      chk("resp_index", got_idx, exp_idx);
      chk("resp_entry", got_ent, exp_ent);
      chk("resp_err", got_err, exp_err);
      chk("we_pulses", we_tot - b_we, exp_we);
      chk("inv_pulses", inv_tot - b_inv, exp_inv);
      chk("fetch_pulses", fetch_tot - b_fetch, exp_fetch);
      if (exp_we == 1) begin
         chk("w_index", w_idx_seen, widx);
         chk("w_entry", w_ent_seen, ent);
      end
      if (exp_inv == 1) begin
         chk("inv_op", iop_seen, iop);
         chk("inv_asid", iasid_seen, ia);
         chk("inv_vpn", ivpn_seen, iv);
      end
      if (exp_fetch == 1) begin
         chk("s1_vppn", vppn_seen, ent[88:70]);
         chk("s1_asid", asid_seen, ent[69:60]);
      end
      handshake();
      chk("tlb_changed_pulses", chg_tot - b_chg, exp_we + exp_inv);
   endtask

   initial begin
      logic [88:0] ent, held;
      logic [2:0]  op;
      logic [4:0]  k;
      int          b_we, b_chg;
      req_valid = 1'b0; req_op = '0; req_index = '0; req_entry = '0;
      req_inv_op = '0; req_inv_asid = '0; req_inv_vpn = '0; resp_ready = 1'b0;
      for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_we", we, 1'b0);
      chk("rst_inv_en", inv_en, 1'b0);
      chk("rst_s1_fetch", s1_fetch, 1'b0);
      chk("rst_tlb_changed", tlb_changed, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_resp_found", resp_found, 1'b0);
      chk("rst_resp_entry", resp_entry, '0);
      chk_on = 1'b1;

      // search hit at slot 7
      run(OP_WR, 5'd7, mk_entry(19'h12345, 10'd3, 1'b0, 1'b1), 5'd0, 10'd0, 19'd0, -1);
      run(OP_SRCH, 5'd0, mk_entry(19'h12345, 10'd3, 1'b0, 1'b0), 5'd0, 10'd0, 19'd0, -1);
      chk("srch_found_7", got_found, 1'b1);
      chk("srch_index_7", got_idx, 5'd7);
      run(OP_SRCH, 5'd0, mk_entry(19'h54321, 10'd3, 1'b0, 1'b0), 5'd0, 10'd0, 19'd0, -1);

      // fill at the top of the counter, then after the wrap
      run(OP_FILL, 5'd2, mk_entry(19'h00aaa, 10'd1, 1'b0, 1'b1), 5'd0, 10'd0, 19'd0, 31);
      chk("fill_at_31", w_idx_seen, 5'd31);
      run(OP_FILL, 5'd2, mk_entry(19'h00bbb, 10'd1, 1'b0, 1'b1), 5'd0, 10'd0, 19'd0, 0);
      chk("fill_wrap_0", w_idx_seen, 5'd0);
      run(OP_FILL, 5'd2, mk_entry(19'h00ccc, 10'd1, 1'b1, 1'b1), 5'd0, 10'd0, 19'd0, -1);

      // read of an invalid then a valid slot 5
      run(OP_WR, 5'd5, mk_entry(19'h0f0f0, 10'd9, 1'b0, 1'b0), 5'd0, 10'd0, 19'd0, -1);
      run(OP_RD, 5'd5, '0, 5'd0, 10'd0, 19'd0, -1);
      chk("rd_invalid_zero", got_ent, '0);
      ent = mk_entry(19'h0f0f0, 10'd9, 1'b0, 1'b1);
      run(OP_WR, 5'd5, ent, 5'd0, 10'd0, 19'd0, -1);
      run(OP_RD, 5'd5, '0, 5'd0, 10'd0, 19'd0, -1);
      chk("rd_valid_entry", got_ent, ent);

      run(OP_INV, 5'd0, '0, 5'd5, 10'h2A, 19'h00100, -1);
      run(OP_INV, 5'd0, '0, 5'd9, 10'h2A, 19'h00100, -1);
      chk("inv_bad_err", got_err, 1'b1);

      // illegal op held in DONE while resp_ready stays low
      send(3'd6, 5'd0, '0, 5'd0, 10'd0, 19'd0, -1, 1'b0);
      chk("illegal_latency", lat, 1);
      chk("illegal_err", got_err, 1'b1);
      held = resp_entry;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_resp_valid", resp_valid, 1'b1);
         chk("hold_resp_err", resp_err, 1'b1);
         chk("hold_resp_entry", resp_entry, held);
         chk("hold_req_ready", req_ready, 1'b0);
      end
      handshake();

      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 7));
         k  = 5'($urandom);
         if (op == OP_SRCH && $urandom_range(0, 2) != 0)
            ent = mk_entry(ref_mem[k][88:70], ref_mem[k][69:60], 1'b0, 1'b0);
         else
            ent = mk_entry(19'($urandom_range(0, 3)), 10'($urandom_range(0, 3)),
                           1'($urandom), 1'($urandom));
         run(op, k, ent, 5'($urandom_range(0, 9)), 10'($urandom), 19'($urandom), -1);
      end

      // reset while the write is pending
      b_we = we_tot;
      b_chg = chg_tot;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_WR; req_index = 5'd12;
      req_entry = mk_entry(19'h77777, 10'd4, 1'b0, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_in_wr_we", we, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;
      @(negedge clk);
      chk("abort_req_ready", req_ready, 1'b1);
      chk("abort_resp_valid", resp_valid, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_resp", resp_valid, 1'b0);
         chk("abort_no_changed", tlb_changed, 1'b0);
      end
      chk("abort_we_count", we_tot - b_we, 0);
      chk("abort_changed_count", chg_tot - b_chg, 0);
      run(OP_FILL, 5'd0, mk_entry(19'h01234, 10'd2, 1'b0, 1'b1), 5'd0, 10'd0, 19'd0, -1);
      run(OP_RD, 5'd12, '0, 5'd0, 10'd0, 19'd0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
